mult_seq_8bits: RTL and testbench



---
 rtl/mult_seq_8bits_pkg.sv | 15 +
 rtl/somadorde8bits.sv | 24 ++
 rtl/mult_seq_8bits.sv | 117 +++++++++++
 tb/tb_mult_seq_8bits.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_8bits_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
// Holds the operand width, the iteration count and the FSM state encodings.
package mult_seq_8bits_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_ITER    = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/somadorde8bits.sv
// 8-bit ripple-carry adder: sum, carry-out and two's-complement overflow flag.
module somadorde8bits (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       Cout,
    output logic       OV
);

    logic [8:0] w_c;

    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fa
            assign S[gi]     = A[gi] ^ B[gi] ^ w_c[gi];
            assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = w_c[8];
    assign OV   = w_c[8] ^ w_c[7];

endmodule

// File: rtl/mult_seq_8bits.sv
// Sequential shift-and-add 8x8 unsigned multiplier with start/busy/done handshake.
// One add/shift per clock through the ripple adder; P and ov update only on completion.
module mult_seq_8bits
    import mult_seq_8bits_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ov
);

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_m, w_m_next;
    logic [WIDTH-1:0]     r_q, w_q_next;
    logic [WIDTH-1:0]     r_acc, w_acc_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [2*WIDTH-1:0]   r_p, w_p_next;
    logic                 r_ov, w_ov_next;
    logic                 r_done, w_done_next;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic                 w_unused_ov;
    logic [WIDTH:0]       w_add_hi;
    logic [2*WIDTH:0]     w_triple;
    logic [WIDTH-1:0]     w_acc_shift;
    logic [WIDTH-1:0]     w_q_shift;

    somadorde8bits u_adder (
        .A    (r_acc),
        .B    (r_m),
        .S    (w_sum),
        .Cout (w_cout),
        .OV   (w_unused_ov)
    );

    // The adder carry becomes bit 16 of the pre-shift value, so no product bit is lost.
    assign w_add_hi    = r_q[0] ? {w_cout, w_sum} : {1'b0, r_acc};
    assign w_triple    = {w_add_hi, r_q};
    assign w_acc_shift = w_triple[2*WIDTH:WIDTH+1];
    assign w_q_shift   = w_triple[WIDTH:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_ov    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_m     <= w_m_next;
            r_q     <= w_q_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_p     <= w_p_next;
            r_ov    <= w_ov_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_m_next     = r_m;
        w_q_next     = r_q;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_p_next     = r_p;
        w_ov_next    = r_ov;
        w_done_next  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A start in DONE is accepted directly, giving a 9-cycle result cadence.
                if (start) begin
                    w_m_next     = A;
                    w_q_next     = B;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_acc_next = w_acc_shift;
                w_q_next   = w_q_shift;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(N_ITER - 1)) begin
                    w_p_next     = {w_acc_shift, w_q_shift};
                    w_ov_next    = |w_acc_shift;
                    w_done_next  = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state == ST_CALC);
    assign done = r_done;
    assign P    = r_p;
    assign ov   = r_ov;

endmodule

// File: tb/tb_mult_seq_8bits.sv
// Self-checking bench for mult_seq_8bits: directed handshake scenarios plus a random
// operand sweep compared against plain A*B arithmetic.
module tb_mult_seq_8bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] P;
    logic        ov;

    int checks;
    int failures;

    mult_seq_8bits #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int unsigned x;
        x = int'(a) * int'(b);
        return x[15:0];
    endfunction

    function automatic logic ref_ov(input logic [7:0] a, input logic [7:0] b);
        int unsigned x;
        x = int'(a) * int'(b);
        return (x > 255);
    endfunction

    // Starts one multiply and observes 12 edges (E0..E11), sampling 1 time unit after each.
    task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] p, output logic pov,
                           output int busy_n, output int done_at, output int done_n);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        busy_n = 0; done_at = -1; done_n = 0; p = 16'hxxxx; pov = 1'bx;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = c;
                    p = P;
                    pov = ov;
                end
            end
        end
        $display("txn a=%02h b=%02h P=%04h ov=%0b done_at=E%0d busy_cycles=%0d", a, b, p, pov, done_at, busy_n);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, P, ov} !== 19'd0) begin
            failures++;
            $display("FAIL reset_during: busy=%b done=%b P=%h ov=%b required all zero", busy, done, P, ov);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, P, ov} !== 19'd0) begin
            failures++;
            $display("FAIL reset_after: busy=%b done=%b P=%h ov=%b required all zero", busy, done, P, ov);
        end
        $display("txn reset busy=%b done=%b P=%04h ov=%b", busy, done, P, ov);
    endtask

    task automatic test_basic();
        logic [15:0] p; logic pov; int bn, da, dn;
        do_mult(8'h0C, 8'h0A, p, pov, bn, da, dn);
        checks++;
        if (p !== 16'h0078 || pov !== 1'b0) begin
            failures++;
            $display("FAIL basic_product: P=%h ov=%b required P=0078 ov=0", p, pov);
        end
        checks++;
        if (bn != 8) begin
            failures++;
            $display("FAIL basic_busy_len: got %0d cycles required 8", bn);
        end
        checks++;
        if (da != 8 || dn != 1) begin
            failures++;
            $display("FAIL basic_done_timing: done_at=E%0d pulses=%0d required E8 and 1", da, dn);
        end
    endtask

    task automatic test_max_hold();
        logic [15:0] p; logic pov; int bn, da, dn;
        do_mult(8'hFF, 8'hFF, p, pov, bn, da, dn);
        checks++;
        if (p !== 16'hFE01 || pov !== 1'b1) begin
            failures++;
            $display("FAIL max_product: P=%h ov=%b required P=FE01 ov=1", p, pov);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (P !== 16'hFE01 || ov !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL max_hold[%0d]: P=%h ov=%b done=%b busy=%b required FE01 1 0 0", i, P, ov, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen2;
        seen2 = -1;
        @(negedge clk);
        A = 8'h00; B = 8'h55; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
            if (c == 8) begin
                checks++;
                if (done !== 1'b1 || P !== 16'h0000 || ov !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_first: done=%b P=%h ov=%b required 1 0000 0", done, P, ov);
                end
                A = 8'h80; B = 8'h02; start = 1'b1;
            end
            if (c == 9) start = 1'b0;
            if (c > 9 && done === 1'b1 && seen2 < 0) seen2 = c;
            if (c == 17) begin
                checks++;
                if (done !== 1'b1 || P !== 16'h0100 || ov !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_second: done=%b P=%h ov=%b required 1 0100 1", done, P, ov);
                end
            end
        end
        checks++;
        if (seen2 != 17) begin
            failures++;
            $display("FAIL b2b_spacing: second done at E%0d required E17", seen2);
        end
        $display("txn b2b 00x55 then 80x02 second_done=E%0d P=%04h ov=%b", seen2, P, ov);
    endtask

    task automatic test_ignore_start();
        int dn, da;
        dn = 0; da = -1;
        @(negedge clk);
        A = 8'h07; B = 8'h06; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
            if (c == 2) begin start = 1'b1; A = 8'hFF; end
            if (c == 3) begin start = 1'b0; B = 8'h99; end
            if (done === 1'b1) begin
                dn++;
                if (da < 0) da = c;
            end
            if (c == 8) begin
                checks++;
                if (done !== 1'b1 || P !== 16'h002A || ov !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_product: done=%b P=%h ov=%b required 1 002A 0", done, P, ov);
                end
            end
        end
        checks++;
        if (dn != 1 || da != 8) begin
            failures++;
            $display("FAIL ignore_pulses: pulses=%0d first=E%0d required 1 at E8", dn, da);
        end
        $display("txn ignore 07x06 P=%04h pulses=%0d", P, dn);
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; logic pov; int bn, da, dn, stray;
        stray = 0;
        @(negedge clk);
        A = 8'h10; B = 8'h10; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000 || ov !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: busy=%b done=%b P=%h ov=%b required all zero", busy, done, P, ov);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_mid_abort: %0d cycles with done/busy, required 0", stray);
        end
        do_mult(8'h03, 8'h05, p, pov, bn, da, dn);
        checks++;
        if (p !== 16'h000F || pov !== 1'b0 || da != 8) begin
            failures++;
            $display("FAIL reset_mid_recover: P=%h ov=%b done_at=E%0d required 000F 0 E8", p, pov, da);
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] p; logic pov; int bn, da, dn;
        logic [7:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_mult(a, b, p, pov, bn, da, dn);
            checks++;
            if (p !== ref_prod(a, b) || pov !== ref_ov(a, b) || da != 8 || dn != 1) begin
                failures++;
                $display("FAIL rand[%0d] %02h*%02h: P=%h ov=%b done_at=E%0d pulses=%0d required P=%h ov=%b E8 1",
                         i, a, b, p, pov, da, dn, ref_prod(a, b), ref_ov(a, b));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
        test_reset();
        test_basic();
        test_max_hold();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
